// File: rtl/kth_ss_apb_master.sv
// APB initiator for the kth_ss slave port: executes write, read and poll-read
// commands from a valid/ready channel and returns one response per command.
module kth_ss_apb_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int POLL_GAP     = 4,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_poll,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam logic [15:0] TIMEOUT_C  = 16'(POLL_TIMEOUT);
  localparam logic [7:0]  GAP_LAST_C = 8'(POLL_GAP - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  pwrite_q, pwrite_d;
  logic                  poll_q, poll_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [15:0]           poll_cnt_q, poll_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic [15:0]           poll_cnt_inc_s;
  logic                  no_match_s;

  assign poll_cnt_inc_s = poll_cnt_q + 16'd1;
  // A zero mask can never match, so such a poll always runs to timeout.
  assign no_match_s     = ((PRDATA & mask_q) == {DATA_WIDTH{1'b0}});

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    mask_d        = mask_q;
    pwrite_d      = pwrite_q;
    poll_d        = poll_q;
    poll_cnt_d    = poll_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_SETUP;
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          poll_d     = cmd_poll & ~cmd_write;
          mask_d     = cmd_wdata;
          poll_cnt_d = 16'd0;
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
          end else begin
            pwdata_d = pwdata_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (poll_q) begin
            poll_cnt_d = poll_cnt_inc_s;
          end else begin
            poll_cnt_d = poll_cnt_q;
          end
          if (poll_q && !PSLVERR && no_match_s && (poll_cnt_inc_s < TIMEOUT_C)) begin
            state_d   = S_GAP;
            gap_cnt_d = 8'd0;
          end else begin
            state_d       = S_RESP;
            rsp_rdata_d   = pwrite_q ? {DATA_WIDTH{1'b0}} : PRDATA;
            rsp_err_d     = PSLVERR;
            rsp_timeout_d = poll_q && !PSLVERR && no_match_s && (poll_cnt_inc_s == TIMEOUT_C);
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST_C) begin
          state_d = S_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake and bus strobes are registered from the next state.
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q       <= S_IDLE;
      paddr_q       <= {ADDR_WIDTH{1'b0}};
      pwdata_q      <= {DATA_WIDTH{1'b0}};
      mask_q        <= {DATA_WIDTH{1'b0}};
      pwrite_q      <= 1'b0;
      poll_q        <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      poll_cnt_q    <= 16'd0;
      gap_cnt_q     <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      mask_q        <= mask_d;
      pwrite_q      <= pwrite_d;
      poll_q        <= poll_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cmd_ready_q   <= cmd_ready_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_kth_ss_apb_master.sv
// Directed bench for kth_ss_apb_master: drives on the falling edge, samples
// on the falling edge, POLL_GAP=4 and POLL_TIMEOUT=5.
module tb_kth_ss_apb_master;

  localparam logic [31:0] CTRL     = 32'h0000_1000;
  localparam logic [31:0] DATA_OUT = 32'h0000_2000;

  logic        clk_in;
  logic        reset_int;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_poll;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int          checks;
  int          errors;
  int          xfers;
  int          xfers_base;
  logic [31:0] exp_pwdata;

  kth_ss_apb_master #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .POLL_GAP    (4),
    .POLL_TIMEOUT(5)
  ) dut (
    .clk_in     (clk_in),
    .reset_int  (reset_int),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_poll   (cmd_poll),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Count completed APB transfers seen on the bus.
  initial xfers = 0;
  always @(posedge clk_in) begin
    if (PSEL && PENABLE && PREADY) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one command at a falling edge; returns one cycle later (in SETUP).
  task automatic issue(input logic wr, input logic poll, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_poll  = poll;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (wr) exp_pwdata = wdata;
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  // Check one SETUP + single-cycle ACCESS, presenting rdata/err; ends one cycle after ACCESS.
  task automatic apb_xfer(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] rdata, input logic err);
    chk({tag, "_setup_psel"},    {31'd0, PSEL},      32'd1);
    chk({tag, "_setup_penable"}, {31'd0, PENABLE},   32'd0);
    chk({tag, "_setup_paddr"},   PADDR,              addr);
    chk({tag, "_setup_pwrite"},  {31'd0, PWRITE},    {31'd0, wr});
    chk({tag, "_setup_pwdata"},  PWDATA,             exp_pwdata);
    chk({tag, "_cmd_ready"},     {31'd0, cmd_ready}, 32'd0);
    PRDATA  = rdata;
    PSLVERR = err;
    @(negedge clk_in);
    chk({tag, "_acc_psel"},    {31'd0, PSEL},    32'd1);
    chk({tag, "_acc_penable"}, {31'd0, PENABLE}, 32'd1);
    chk({tag, "_acc_paddr"},   PADDR,            addr);
    chk({tag, "_acc_pwrite"},  {31'd0, PWRITE},  {31'd0, wr});
    chk({tag, "_acc_pwdata"},  PWDATA,           exp_pwdata);
    @(negedge clk_in);
    PSLVERR = 1'b0;
    PRDATA  = 32'hBAD0_BAD0;
    chk({tag, "_post_psel"},    {31'd0, PSEL},    32'd0);
    chk({tag, "_post_penable"}, {31'd0, PENABLE}, 32'd0);
  endtask

  // Four idle cycles between poll reads; ends on the next SETUP cycle.
  task automatic gap_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_gap_psel"},      {31'd0, PSEL},      32'd0);
      chk({tag, "_gap_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk_in);
    end
  endtask

  task automatic resp_check(input string tag, input logic [31:0] rdata, input logic err,
                            input logic tmo);
    chk({tag, "_rsp_valid"},   {31'd0, rsp_valid},   32'd1);
    chk({tag, "_rsp_rdata"},   rsp_rdata,            rdata);
    chk({tag, "_rsp_err"},     {31'd0, rsp_err},     {31'd0, err});
    chk({tag, "_rsp_timeout"}, {31'd0, rsp_timeout}, {31'd0, tmo});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_pwdata = 32'd0;
    reset_int  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_poll   = 1'b0;
    cmd_addr   = 32'd0;
    cmd_wdata  = 32'd0;
    rsp_ready  = 1'b1;
    PRDATA     = 32'd0;
    PREADY     = 1'b1;
    PSLVERR    = 1'b0;

    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_psel",        {31'd0, PSEL},        32'd0);
    chk("rst_penable",     {31'd0, PENABLE},     32'd0);
    chk("rst_pwrite",      {31'd0, PWRITE},      32'd0);
    chk("rst_paddr",       PADDR,                32'd0);
    chk("rst_pwdata",      PWDATA,               32'd0);
    chk("rst_rsp_valid",   {31'd0, rsp_valid},   32'd0);
    chk("rst_rsp_rdata",   rsp_rdata,            32'd0);
    chk("rst_rsp_err",     {31'd0, rsp_err},     32'd0);
    chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
    reset_int = 1'b1;
    @(negedge clk_in);

    // Plain write, zero wait states.
    xfers_base = xfers;
    issue(1'b1, 1'b0, CTRL + 32'h4, 32'h0000_0001);
    apb_xfer("wr", CTRL + 32'h4, 1'b1, 32'h5555_5555, 1'b0);
    resp_check("wr", 32'd0, 1'b0, 1'b0);
    chk("wr_xfers", 32'(xfers - xfers_base), 32'd1);
    @(negedge clk_in);
    chk("wr_rsp_drop", {31'd0, rsp_valid}, 32'd0);

    // Read with three wait states: ACCESS lasts four cycles.
    issue(1'b0, 1'b0, DATA_OUT + 32'h8, 32'hFFFF_0000);
    chk("rd_setup_psel",    {31'd0, PSEL},    32'd1);
    chk("rd_setup_penable", {31'd0, PENABLE}, 32'd0);
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("rd_wait_psel",    {31'd0, PSEL},    32'd1);
      chk("rd_wait_penable", {31'd0, PENABLE}, 32'd1);
      chk("rd_wait_paddr",   PADDR,            DATA_OUT + 32'h8);
      chk("rd_wait_pwrite",  {31'd0, PWRITE},  32'd0);
      chk("rd_wait_pwdata",  PWDATA,           exp_pwdata);
      if (i == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk_in);
    PRDATA = 32'd0;
    chk("rd_post_psel", {31'd0, PSEL}, 32'd0);
    resp_check("rd", 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk_in);

    // Poll that matches on its third read.
    xfers_base = xfers;
    issue(1'b0, 1'b1, CTRL + 32'h8, 32'h0000_0001);
    apb_xfer("poll1", CTRL + 32'h8, 1'b0, 32'h0000_0000, 1'b0);
    gap_check("poll1");
    apb_xfer("poll2", CTRL + 32'h8, 1'b0, 32'h0000_0002, 1'b0);
    gap_check("poll2");
    apb_xfer("poll3", CTRL + 32'h8, 1'b0, 32'h0000_0001, 1'b0);
    resp_check("poll", 32'h0000_0001, 1'b0, 1'b0);
    chk("poll_xfers", 32'(xfers - xfers_base), 32'd3);
    @(negedge clk_in);

    // Poll that never matches: five reads then timeout.
    xfers_base = xfers;
    issue(1'b0, 1'b1, CTRL + 32'h8, 32'h0000_0001);
    for (int r = 0; r < 5; r++) begin
      apb_xfer("tmo", CTRL + 32'h8, 1'b0, 32'h0000_0000, 1'b0);
      if (r < 4) gap_check("tmo");
    end
    resp_check("tmo", 32'd0, 1'b0, 1'b1);
    chk("tmo_xfers", 32'(xfers - xfers_base), 32'd5);
    @(negedge clk_in);

    // Write that ends in a slave error.
    issue(1'b1, 1'b0, CTRL, 32'hCAFE_0042);
    apb_xfer("wrerr", CTRL, 1'b1, 32'h0000_0000, 1'b1);
    resp_check("wrerr", 32'd0, 1'b1, 1'b0);
    @(negedge clk_in);

    // Poll aborted by an error on its second read.
    xfers_base = xfers;
    issue(1'b0, 1'b1, CTRL + 32'h8, 32'h0000_0001);
    apb_xfer("perr1", CTRL + 32'h8, 1'b0, 32'h0000_0000, 1'b0);
    gap_check("perr");
    apb_xfer("perr2", CTRL + 32'h8, 1'b0, 32'h0000_0000, 1'b1);
    resp_check("perr", 32'd0, 1'b1, 1'b0);
    chk("perr_xfers", 32'(xfers - xfers_base), 32'd2);
    @(negedge clk_in);

    // Poll bit with a write is a plain write (zero mask would otherwise time out).
    xfers_base = xfers;
    issue(1'b1, 1'b1, CTRL + 32'hC, 32'h0000_0000);
    apb_xfer("wrpoll", CTRL + 32'hC, 1'b1, 32'h0000_0000, 1'b0);
    resp_check("wrpoll", 32'd0, 1'b0, 1'b0);
    chk("wrpoll_xfers", 32'(xfers - xfers_base), 32'd1);
    @(negedge clk_in);

    // Response back-pressure for ten cycles.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, DATA_OUT, 32'd0);
    apb_xfer("bp", DATA_OUT, 1'b0, 32'hA5A5_0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      resp_check("bp", 32'hA5A5_0001, 1'b0, 1'b0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk_in);
    end
    rsp_ready = 1'b1;
    @(negedge clk_in);
    chk("bp_rsp_drop", {31'd0, rsp_valid}, 32'd0);

    // Reset in the middle of an ACCESS cycle.
    issue(1'b1, 1'b0, CTRL + 32'h10, 32'h0BAD_F00D);
    PREADY = 1'b0;
    @(negedge clk_in);
    chk("rst_mid_penable_pre", {31'd0, PENABLE}, 32'd1);
    #2;
    reset_int = 1'b0;
    #1;
    chk("rst_mid_psel",      {31'd0, PSEL},      32'd0);
    chk("rst_mid_penable",   {31'd0, PENABLE},   32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    exp_pwdata = 32'd0;
    @(negedge clk_in);
    reset_int = 1'b1;
    PREADY    = 1'b1;
    @(negedge clk_in);
    issue(1'b1, 1'b0, CTRL + 32'h14, 32'h0000_0077);
    apb_xfer("after_rst", CTRL + 32'h14, 1'b1, 32'h0000_0000, 1'b0);
    resp_check("after_rst", 32'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("after_rst_idle", {31'd0, cmd_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kth_ss_apb_master.md
Name: kth_ss_apb_master

Overview:
- Hardware APB initiator that drives the kth_ss APB slave port.
- An on-chip sequencer (loader FSM or host bridge) hands it single-word commands: write, read, or poll-read. It issues a compliant APB SETUP/ACCESS transfer for each, honouring PREADY wait states and capturing PSLVERR.
- Poll mode repeatedly reads one address until masked bits are set, for example the fabric "ret" status register after the start bit is written.
- The block returns one response per command on a valid/ready channel.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA/PRDATA and the data fields.
- POLL_GAP, 4, number of idle cycles (PSEL=0) between successive poll reads; legal range 1..255.
- POLL_TIMEOUT, 65535, maximum number of poll reads before abandoning; legal range 1..2^16-1.

Ports:
- clk_in  input  1  system clock; all flops on the rising edge.
- reset_int  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_poll  input  1  valid only with cmd_write=0; selects poll-read.
- cmd_addr  input  ADDR_WIDTH  target address.
- cmd_wdata  input  DATA_WIDTH  write data; used as the poll mask when cmd_poll=1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DATA_WIDTH  read data of the final read; 0 for writes.
- rsp_err  output  1  PSLVERR was sampled high on the final transfer.
- rsp_timeout  output  1  poll abandoned after POLL_TIMEOUT reads.
- PADDR  output  ADDR_WIDTH  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0. The state is IDLE and cmd_ready=1.
- States are IDLE, SETUP, ACCESS, GAP and RESP. cmd_ready is 1 only in IDLE.
- IDLE: on a command handshake at edge k, latch addr, write, poll and wdata; clear the poll counter; go to SETUP.
  - Cycle k+1 (SETUP): PSEL=1, PENABLE=0.
  - Cycle k+2 (ACCESS): PSEL=1, PENABLE=1.
- Writes drive PWDATA=cmd_wdata. For reads and polls, PWDATA holds its previous value and PWRITE=0.
- PADDR, PWRITE and PWDATA are registered. They must not change from SETUP through the ACCESS cycle in which PREADY=1.
- ACCESS with PREADY=0: stay in ACCESS; all APB outputs are held. Wait states are unbounded.
- ACCESS with PREADY=1 (completion): the next cycle has PSEL=0 and PENABLE=0. The poll counter increments for poll commands.
  - Poll-read with PSLVERR=0, (PRDATA & mask)==0 and counter < POLL_TIMEOUT: go to GAP.
  - Otherwise: go to RESP. Latch rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, and rsp_timeout=1 only if this was a poll whose mask test failed with counter == POLL_TIMEOUT.
- GAP: idle for exactly POLL_GAP cycles, then go to SETUP with the same address.
- RESP: rsp_valid=1 and the response fields are held stable until rsp_ready=1. On that edge go to IDLE and drop rsp_valid.
- rsp_ready held high gives a minimum cadence of 4 cycles per write/read command: IDLE, SETUP, ACCESS, RESP.
- Latency: rsp_valid rises on the edge after the completing ACCESS cycle.
- PSLVERR=1 during a poll ends the poll immediately with rsp_err=1 and rsp_timeout=0.
- A mask of 0 never matches, so the poll always ends in a timeout (POLL_TIMEOUT reads).
- cmd_poll=1 with cmd_write=1: the poll bit is ignored and a plain write is issued.
- The poll counter is 16 bits wide and never wraps, because it is bounded by POLL_TIMEOUT.
- Reset asserted mid-transfer: PSEL and PENABLE drop asynchronously, the in-flight command and any pending response are discarded, and the state is IDLE after deassertion.
- PRDATA, PSLVERR and PREADY are ignored outside ACCESS.

Test Plan:
- Reset then write 0x00000001 to CTRL+0x4 with PREADY tied 1: PSEL high for 2 cycles, PENABLE high in the 2nd cycle only, PWRITE=1, rsp_valid 1 cycle after ACCESS, rsp_err=0, rsp_rdata=0.
- Read DATA_OUT+0x8 with PREADY low for 3 ACCESS cycles and PRDATA=0xDEADBEEF: ACCESS lasts 4 cycles, PADDR/PWRITE stable throughout, rsp_rdata=0xDEADBEEF.
- Poll CTRL+0x8 with mask 0x1; the slave returns 0, 0, then 0x1: exactly 3 APB reads, each separated by POLL_GAP=4 idle cycles, rsp_rdata=0x1, rsp_timeout=0.
- Poll with mask 0x1, slave always returns 0, POLL_TIMEOUT=5: 5 reads, then rsp_timeout=1 and rsp_err=0.
- Error cases:
  - Write with PSLVERR=1 on completion: rsp_err=1.
  - Poll receiving PSLVERR=1 on its 2nd read: polling stops, rsp_err=1, rsp_timeout=0.
- Robustness: hold rsp_ready=0 for 10 cycles (rsp_valid and fields stable, cmd_ready=0), then assert reset_int=0 during ACCESS of the next command. PSEL and PENABLE must be 0 immediately, and the first command after reset completes normally.
